// File: rtl/mult_div_ctrl_if.sv
// E-stage <-> multiply/divide unit bundle: op request, forwarded operands, D-stage HI/LO-use flag,
// and the unit's busy/stall/HI/LO outputs. No handshake: the hazard unit stalls on 'stall'.
interface mult_div_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_D,
    input  busy, stall, HI, LO
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_D,
    output busy, stall, HI, LO
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// HI/LO owner for the MIPS E stage: mult/div results land MULT_CYCLES/DIV_CYCLES edges after accept,
// mthi/mtlo land at the accept edge; starts while busy are dropped, so 'stall' holds off HI/LO users.
module mult_div_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mult_div_ctrl_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      shadow_hi_q, shadow_hi_d;
  logic [31:0]      shadow_lo_q, shadow_lo_d;

  logic        busy;
  logic        accept;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        div_signed, neg_a, neg_b, div_by_zero;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag;
  logic [31:0] div_q, div_r;

  // One 64-bit multiplier serves both flavours: the low 64 bits of the product of the
  // sign- or zero-extended operands are the exact signed or unsigned 32x32 result.
  always_comb begin : mul_path
    mul_a = md.md_op[0] ? {32'd0, md.rs_val} : {{32{md.rs_val[31]}}, md.rs_val};
    mul_b = md.md_op[0] ? {32'd0, md.rt_val} : {{32{md.rt_val[31]}}, md.rt_val};
    mul_p = mul_a * mul_b;
  end

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  always_comb begin : div_path
    div_signed  = ~md.md_op[0];
    div_by_zero = (md.rt_val == 32'd0);
    neg_a       = div_signed & md.rs_val[31];
    neg_b       = div_signed & md.rt_val[31];
    mag_a       = neg_a ? (~md.rs_val + 32'd1) : md.rs_val;
    mag_b       = neg_b ? (~md.rt_val + 32'd1) : md.rt_val;
    div_b       = div_by_zero ? 32'd1 : mag_b;
    q_mag       = mag_a / div_b;
    r_mag       = mag_a % div_b;
    if (div_by_zero) begin
      div_q = 32'hFFFF_FFFF;
      div_r = md.rs_val;
    end else begin
      div_q = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
      div_r = neg_a ? (~r_mag + 32'd1) : r_mag;
    end
  end

  assign busy   = (state_q == RUN);
  assign accept = md.start && (state_q == IDLE) && (md.md_op <= 3'd5);

  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (md.md_op)
            3'd0, 3'd1: begin
              shadow_hi_d = mul_p[63:32];
              shadow_lo_d = mul_p[31:0];
              cnt_d       = CNT_W'(MULT_CYCLES);
              state_d     = RUN;
            end
            3'd2, 3'd3: begin
              shadow_hi_d = div_r;
              shadow_lo_d = div_q;
              cnt_d       = CNT_W'(DIV_CYCLES);
              state_d     = RUN;
            end
            3'd4:    hi_d = md.rs_val;
            3'd5:    lo_d = md.rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = shadow_hi_q;
          lo_d    = shadow_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
    end
  end

  // The accept cycle is covered too, so a following HI/LO reader never sees the stale value.
  assign md.busy  = busy;
  assign md.stall = md.md_use_D & (busy | (md.start & (md.md_op <= 3'd3)));
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed table, hand-written corner sequences, and random traffic
// checked every cycle against a cycle-count scoreboard of HI/LO.
module tb_mult_div_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;

  mult_div_ctrl_if md_if ();

  mult_div_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md_if.slave)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Scoreboard: architectural HI/LO plus one pending result due at cycle done_cyc.
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  bit          m_pend;
  int          cyc, done_cyc;

  logic        s_busy, s_stall;
  logic [31:0] s_hi, s_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = a;
    sb = b;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      3'd0: begin
        sp = longint'(sa) * longint'(sb);
        hi = sp[63:32];
        lo = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      3'd2: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_pend = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] h, l;
    bit          acc;
    acc = md_if.start && !m_pend && (md_if.md_op <= 3'd5);
    cyc++;
    if (acc) begin
      if (md_if.md_op <= 3'd3) begin
        ref_result(md_if.md_op, md_if.rs_val, md_if.rt_val, h, l);
        m_pend_hi = h;
        m_pend_lo = l;
        m_pend    = 1'b1;
        done_cyc  = cyc + ((md_if.md_op <= 3'd1) ? MC : DC);
      end else if (md_if.md_op == 3'd4) begin
        m_hi = md_if.rs_val;
      end else begin
        m_lo = md_if.rs_val;
      end
    end
    if (m_pend && cyc == done_cyc) begin
      m_hi   = m_pend_hi;
      m_lo   = m_pend_lo;
      m_pend = 1'b0;
    end
  endtask

  // Sample/compare at the falling edge, advance the model at the rising edge, return at posedge+1.
  task automatic tick();
    logic exp_stall;
    @(negedge clk);
    s_busy    = md_if.busy;
    s_stall   = md_if.stall;
    s_hi      = md_if.HI;
    s_lo      = md_if.LO;
    exp_stall = md_if.md_use_D & (m_pend | (md_if.start & (md_if.md_op <= 3'd3)));
    chk("busy",  {31'd0, s_busy},  {31'd0, m_pend});
    chk("stall", {31'd0, s_stall}, {31'd0, exp_stall});
    chk("HI",    s_hi, m_hi);
    chk("LO",    s_lo, m_lo);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_d);
    md_if.start    = st;
    md_if.md_op    = op;
    md_if.rs_val   = a;
    md_if.rt_val   = b;
    md_if.md_use_D = use_d;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt, scnt;
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    done_cyc = 0;
    model_reset();

    tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MC};
    tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, MC};
    tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    tbl[3] = '{3'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, DC};
    tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
    tbl[5] = '{3'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, DC};
    tbl[6] = '{3'd3, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, DC};
    tbl[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
    tbl[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MC};
    tbl[9] = '{3'd3, 32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, DC};

    reset = 1'b1;
    drive(0, 3'd0, 32'd0, 32'd0, 0);
    #12;
    chk("rst_busy", {31'd0, md_if.busy}, 32'd0);
    chk("rst_HI", md_if.HI, 32'd0);
    chk("rst_LO", md_if.LO, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    tick();

    // Directed table: latency and final HI/LO against hand-computed constants.
    for (int k = 0; k < 10; k++) begin
      drive(1, tbl[k].op, tbl[k].a, tbl[k].b, 0);
      tick();
      drive(0, 3'd0, $urandom, $urandom, 0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (s_busy) cnt++;
        else break;
      end
      chk($sformatf("lat[%0d]", k), 32'(cnt), 32'(tbl[k].lat));
      chk($sformatf("hi[%0d]", k), s_hi, tbl[k].hi);
      chk($sformatf("lo[%0d]", k), s_lo, tbl[k].lo);
    end

    // A mult start held during a div run must be ignored.
    drive(1, 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    tick();
    drive(1, 3'd0, 32'd3, 32'd3, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 2) drive(0, 3'd0, 32'd0, 32'd0, 0);
      if (s_busy) cnt++;
      else break;
    end
    chk("ovl_lat", 32'(cnt), 32'(DC));
    chk("ovl_hi", s_hi, 32'hFFFF_FFFF);
    chk("ovl_lo", s_lo, 32'hFFFF_FFFD);

    // mthi / mtlo take effect at the accept edge; reserved ops change nothing.
    drive(1, 3'd4, 32'h1234_5678, 32'd0, 0);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0, 0);
    tick();
    chk("mthi_hi", s_hi, 32'h1234_5678);
    chk("mthi_lo", s_lo, 32'hFFFF_FFFD);
    chk("mthi_busy", {31'd0, s_busy}, 32'd0);
    drive(1, 3'd5, 32'hCAFE_F00D, 32'd0, 0);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0, 0);
    tick();
    chk("mtlo_hi", s_hi, 32'h1234_5678);
    chk("mtlo_lo", s_lo, 32'hCAFE_F00D);
    drive(1, 3'd6, 32'hDEAD_BEEF, 32'd1, 0);
    tick();
    drive(1, 3'd7, 32'hDEAD_BEEF, 32'd1, 0);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0, 0);
    tick();
    chk("rsv_hi", s_hi, 32'h1234_5678);
    chk("rsv_lo", s_lo, 32'hCAFE_F00D);
    chk("rsv_busy", {31'd0, s_busy}, 32'd0);

    // Stall covers the accept cycle plus every busy cycle when a HI/LO user waits in D.
    drive(1, 3'd0, 32'd2, 32'd3, 1);
    tick();
    scnt = s_stall ? 1 : 0;
    drive(0, 3'd0, 32'd0, 32'd0, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!s_busy) break;
      if (s_stall) scnt++;
    end
    chk("stall_cnt", 32'(scnt), 32'(MC + 1));
    chk("stall_end", {31'd0, s_stall}, 32'd0);
    drive(1, 3'd0, 32'd2, 32'd3, 0);
    tick();
    scnt = s_stall ? 1 : 0;
    drive(0, 3'd0, 32'd0, 32'd0, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_stall) scnt++;
      if (!s_busy) break;
    end
    chk("nostall_cnt", 32'(scnt), 32'd0);

    // Reset in the third busy cycle of a div aborts it; the result must never appear.
    drive(1, 3'd3, 32'd100, 32'd7, 0);
    tick();
    drive(0, 3'd0, 32'd0, 32'd0, 0);
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, md_if.busy}, 32'd0);
    chk("arst_hi", md_if.HI, 32'd0);
    chk("arst_lo", md_if.LO, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("post_rst_hi", s_hi, 32'd0);
    chk("post_rst_lo", s_lo, 32'd0);

    // Random traffic, including starts while busy and reserved ops.
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            bit'($urandom_range(0, 1)));
      tick();
    end
    drive(0, 3'd0, 32'd0, 32'd0, 0);
    for (int i = 0; i < DC + 2; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
